// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC and issues single-outstanding word fetches, presenting each word with its PC to Decode.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets on fault instead of silently aligning them.
//
// state   | meaning
// IDLE    | first cycle after reset, no request issued yet
// REQ     | request outstanding at imem_addr
// HOLD    | instruction presented to Decode, waiting for handshake
// DISCARD | outstanding request made stale by a redirect; its response is dropped
// FAULT   | misaligned redirect seen; fetching stopped until reset
module fetch_unit #(
   parameter int              WORD      = 64,
   parameter int              INSTR_LEN = 32,
   parameter logic [WORD-1:0] RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 imem_req,
   output logic [WORD-1:0]      imem_addr,
   input  logic                 imem_ack,
   input  logic [INSTR_LEN-1:0] imem_rdata,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   output logic [INSTR_LEN-1:0] instruction,
   output logic [WORD-1:0]      instr_pc,
   input  logic                 redirect,
   input  logic [WORD-1:0]      redirect_pc,
   output logic                 fault
);

   typedef enum logic [2:0] {IDLE, REQ, HOLD, DISCARD, FAULT} state_t;

   localparam logic [WORD-1:0] PC_STEP    = WORD'(4);
   localparam logic [WORD-1:0] ALIGN_MASK = ~WORD'(3);

   state_t                 state, state_nxt;
   logic [WORD-1:0]        pc, pc_nxt;
   logic                   req_nxt;
   logic [WORD-1:0]        addr_nxt;
   logic                   valid_nxt;
   logic [INSTR_LEN-1:0]   instr_nxt;
   logic [WORD-1:0]        ipc_nxt;
   logic                   fault_nxt;
   logic [WORD-1:0]        target;
   logic                   bad_redir;
   logic                   good_redir;

`ifdef FETCH_ALIGN_CHECK_EN
   assign bad_redir = redirect & (redirect_pc[1:0] != 2'b00);
   assign target    = redirect_pc;
`else
   assign bad_redir = 1'b0;
   assign target    = redirect_pc & ALIGN_MASK;
`endif
   assign good_redir = redirect & ~bad_redir;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         instr_valid <= 1'b0;
         instruction <= '0;
         instr_pc    <= '0;
         fault       <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         imem_req    <= req_nxt;
         imem_addr   <= addr_nxt;
         instr_valid <= valid_nxt;
         instruction <= instr_nxt;
         instr_pc    <= ipc_nxt;
         fault       <= fault_nxt;
      end
   end

   // Redirect outranks ack and handshake in every state.
   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      req_nxt   = imem_req;
      addr_nxt  = imem_addr;
      valid_nxt = instr_valid;
      instr_nxt = instruction;
      ipc_nxt   = instr_pc;
      fault_nxt = fault;
      case (state)
         IDLE: begin
            if (bad_redir) begin
               fault_nxt = 1'b1;
               state_nxt = FAULT;
            end else begin
               state_nxt = REQ;
               req_nxt   = 1'b1;
               pc_nxt    = good_redir ? target : pc;
               addr_nxt  = good_redir ? target : pc;
            end
         end
         REQ: begin
            if (bad_redir) begin
               fault_nxt = 1'b1;
               if (imem_ack) begin
                  req_nxt   = 1'b0;
                  state_nxt = FAULT;
               end else begin
                  state_nxt = DISCARD;
               end
            end else if (good_redir) begin
               pc_nxt = target;
               if (imem_ack) addr_nxt = target;
               else          state_nxt = DISCARD;
            end else if (imem_ack) begin
               instr_nxt = imem_rdata;
               ipc_nxt   = imem_addr;
               valid_nxt = 1'b1;
               req_nxt   = 1'b0;
               pc_nxt    = pc + PC_STEP;
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (redirect) begin
               valid_nxt = 1'b0;
               if (bad_redir) begin
                  fault_nxt = 1'b1;
                  state_nxt = FAULT;
               end else begin
                  pc_nxt    = target;
                  req_nxt   = 1'b1;
                  addr_nxt  = target;
                  state_nxt = REQ;
               end
            end else if (instr_ready) begin
               valid_nxt = 1'b0;
               req_nxt   = 1'b1;
               addr_nxt  = pc;
               state_nxt = REQ;
            end
         end
         DISCARD: begin
            // A pending fault freezes pc; the stale ack then leads into FAULT.
            if (!fault) begin
               if (bad_redir)       fault_nxt = 1'b1;
               else if (good_redir) pc_nxt    = target;
            end
            if (imem_ack) begin
               if (fault || bad_redir) begin
                  req_nxt   = 1'b0;
                  state_nxt = FAULT;
               end else begin
                  addr_nxt  = good_redir ? target : pc;
                  state_nxt = REQ;
               end
            end
         end
         FAULT: begin
            req_nxt   = 1'b0;
            valid_nxt = 1'b0;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
